mem_wb_stage: RTL and testbench

- Consumer end of the EX/MEM pipeline register.
- Takes the registered EX/MEM bundle (memtoReg, memWrite, jal, regWrite, incremented PC, destination register, ALU result, store data).
- Performs loads and stores over a req/ack data-memory handshake, stalling the pipeline while memory is busy.
- Drives the registered MEM/WB bundle: regWrite, destination register, selected writeback value.

---
 rtl/mem_wb_stage.sv | 129 ++++++++++++
 tb/tb_mem_wb_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: performs loads and stores over a req/ack data-memory port and registers the writeback bundle.
// Latency: 1 cycle for non-memory ops; 1 issue cycle plus k wait cycles for memory ops (k = cycle carrying mem_ack, or TIMEOUT).
// Backpressure: combinational stall holds EX/MEM and upstream while an access is being issued or is waiting for mem_ack.
module mem_wb_stage #(
    parameter int DBITS   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memtoReg_m,
    input  logic             memWrite_m,
    input  logic             jal_m,
    input  logic             regWrite_m,
    input  logic [DBITS-1:0] incrementedPC_m,
    input  logic [DBITS-1:0] dstReg_m,
    input  logic [DBITS-1:0] aluOut_m,
    input  logic [DBITS-1:0] dataFwdOut2_m,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [DBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [DBITS-1:0] mem_rdata,
    output logic             regWrite_w,
    output logic [DBITS-1:0] dstReg_w,
    output logic [DBITS-1:0] wbData_w,
    output logic             mem_err
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             lat_load;
    logic             lat_jal;
    logic [DBITS-1:0] lat_dst;
    logic [DBITS-1:0] lat_pc;

    // A flushed bubble may carry memtoReg without regWrite; it must not load.
    logic is_load, is_store, is_mem, cnt_last;
    assign is_load  = memtoReg_m & regWrite_m;
    assign is_store = memWrite_m;
    assign is_mem   = is_load | is_store;
    assign cnt_last = (cnt == CNT_LAST);

    // Hold upstream while issuing, and while waiting unless this cycle ends the access.
    always_comb begin
        stall = 1'b0;
        case (state)
            S_IDLE:  stall = is_mem;
            S_WAIT:  stall = ~(mem_ack | cnt_last);
            default: stall = 1'b0;
        endcase
    end

    // Access sequencing, memory port registers and writeback registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            regWrite_w <= 1'b0;
            dstReg_w   <= '0;
            wbData_w   <= '0;
            mem_err    <= 1'b0;
            lat_load   <= 1'b0;
            lat_jal    <= 1'b0;
            lat_dst    <= '0;
            lat_pc     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_mem) begin
                        mem_req    <= 1'b1;
                        mem_we     <= is_store;
                        mem_addr   <= aluOut_m;
                        mem_wdata  <= dataFwdOut2_m;
                        // A store wins when both store and load are flagged.
                        lat_load   <= is_load & ~is_store;
                        lat_jal    <= jal_m;
                        lat_dst    <= dstReg_m;
                        lat_pc     <= incrementedPC_m;
                        cnt        <= '0;
                        regWrite_w <= 1'b0;
                        state      <= S_WAIT;
                    end else begin
                        regWrite_w <= regWrite_m;
                        dstReg_w   <= dstReg_m;
                        wbData_w   <= jal_m ? incrementedPC_m : aluOut_m;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        regWrite_w <= lat_load;
                        if (lat_load) begin
                            dstReg_w <= lat_dst;
                            wbData_w <= lat_jal ? lat_pc : mem_rdata;
                        end
                        state <= S_IDLE;
                    end else if (cnt_last) begin
                        // Abort: a load still retires, with zero data, so the register file stays consistent.
                        mem_req    <= 1'b0;
                        mem_err    <= 1'b1;
                        regWrite_w <= lat_load;
                        if (lat_load) begin
                            dstReg_w <= lat_dst;
                            wbData_w <= '0;
                        end
                        state <= S_IDLE;
                    end else begin
                        cnt        <= cnt + CW'(1);
                        regWrite_w <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases followed by randomized ops against a transaction-level model.
// Latency: bench is cycle-stepped; every access is bounded by the DUT timeout so no unbounded waits exist.
// Backpressure: the memory responder acks after a chosen latency, or never (forcing a timeout).
module tb_mem_wb_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memtoReg_m, memWrite_m, jal_m, regWrite_m;
    logic [31:0] incrementedPC_m, dstReg_m, aluOut_m, dataFwdOut2_m;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        regWrite_w, mem_err;
    logic [31:0] dstReg_w, wbData_w;

    int tests = 0;
    int fails = 0;
    logic err_m = 1'b0;

    mem_wb_stage #(.DBITS(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .memtoReg_m(memtoReg_m), .memWrite_m(memWrite_m), .jal_m(jal_m), .regWrite_m(regWrite_m),
        .incrementedPC_m(incrementedPC_m), .dstReg_m(dstReg_m), .aluOut_m(aluOut_m),
        .dataFwdOut2_m(dataFwdOut2_m), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .regWrite_w(regWrite_w), .dstReg_w(dstReg_w), .wbData_w(wbData_w), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic scramble;
        memtoReg_m      = 1'($urandom);
        memWrite_m      = 1'($urandom);
        jal_m           = 1'($urandom);
        regWrite_m      = 1'($urandom);
        incrementedPC_m = $urandom;
        dstReg_m        = $urandom;
        aluOut_m        = $urandom;
        dataFwdOut2_m   = $urandom;
    endtask

    // One op through the stage. k = cycle in WAIT that carries mem_ack; k > TO means no ack.
    task automatic run_op(input logic mt, input logic mw, input logic jl, input logic rw,
                          input logic [31:0] pc, input logic [31:0] dst, input logic [31:0] alu,
                          input logic [31:0] wd, input int k, input logic [31:0] rd);
        logic ld, st, tmo, exp_rw;
        ld = mt & rw;
        st = mw;
        tmo = 1'b0;
        memtoReg_m = mt; memWrite_m = mw; jal_m = jl; regWrite_m = rw;
        incrementedPC_m = pc; dstReg_m = dst; aluOut_m = alu; dataFwdOut2_m = wd;
        // A stray ack with no request outstanding must be ignored.
        mem_ack = (ld | st) ? 1'b0 : 1'($urandom);
        mem_rdata = $urandom;
        #1;
        chk("stall_issue", 32'(stall), 32'(ld | st));
        tick;
        if (!(ld | st)) begin
            chk("alu_req", 32'(mem_req), 32'd0);
            chk("alu_rw", 32'(regWrite_w), 32'(rw));
            chk("alu_dst", dstReg_w, dst);
            chk("alu_wb", wbData_w, jl ? pc : alu);
        end else begin
            for (int c = 1; c <= TO; c++) begin
                scramble();
                mem_ack   = (c == k);
                mem_rdata = (c == k) ? rd : $urandom;
                chk("wait_req", 32'(mem_req), 32'd1);
                chk("wait_we", 32'(mem_we), 32'(st));
                chk("wait_addr", mem_addr, alu);
                chk("wait_wdata", mem_wdata, wd);
                chk("wait_rw", 32'(regWrite_w), 32'd0);
                #1;
                chk("wait_stall", 32'(stall), 32'(!(c == k || c == TO)));
                tick;
                if (c == k) break;
                if (c == TO) tmo = 1'b1;
            end
            mem_ack = 1'b0;
            err_m = err_m | tmo;
            exp_rw = ld & ~st;
            chk("done_req", 32'(mem_req), 32'd0);
            chk("done_rw", 32'(regWrite_w), 32'(exp_rw));
            if (exp_rw) begin
                chk("done_dst", dstReg_w, dst);
                chk("done_wb", wbData_w, tmo ? 32'd0 : (jl ? pc : rd));
            end
        end
        chk("mem_err", 32'(mem_err), 32'(err_m));
    endtask

    initial begin
        reset = 1'b1;
        memtoReg_m = 1'b0; memWrite_m = 1'b0; jal_m = 1'b0; regWrite_m = 1'b0;
        incrementedPC_m = '0; dstReg_m = '0; aluOut_m = '0; dataFwdOut2_m = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick;
        tick;
        reset = 1'b0;
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rw", 32'(regWrite_w), 32'd0);
        chk("rst_dst", dstReg_w, 32'd0);
        chk("rst_wb", wbData_w, 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // ALU op
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'd5, 32'h1234, 32'h0, 0, 32'h0);
        // Load, ack on third request cycle
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 32'h48, 32'd7, 32'h100, 32'h0, 3, 32'hCAFEF00D);
        // Store, ack on first request cycle
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h4C, 32'd0, 32'h200, 32'hDEADBEEF, 1, 32'h0);
        // Flushed bubble
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h50, 32'd9, 32'h300, 32'h0, 0, 32'h0);
        // Jal-flagged load writes back the PC
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h54, 32'd31, 32'h104, 32'h0, 2, 32'h11112222);
        // Load and store flagged together: treated as a store
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h58, 32'd3, 32'h204, 32'h55AA55AA, 2, 32'h0);
        // Load timing out
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 32'h5C, 32'd12, 32'h108, 32'h0, TO + 5, 32'h0);

        // Randomized ops; k = TO+1 forces a timeout
        for (int n = 0; n < 80; n++) begin
            run_op(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom), $urandom, 32'($urandom_range(0, 31)), $urandom, $urandom,
                   int'($urandom_range(1, TO + 1)), $urandom);
        end

        // Reset while waiting on a load
        memtoReg_m = 1'b1; memWrite_m = 1'b0; jal_m = 1'b0; regWrite_m = 1'b1;
        dstReg_m = 32'd4; aluOut_m = 32'h400; mem_ack = 1'b0;
        tick;
        tick;
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        err_m = 1'b0;
        memtoReg_m = 1'b0; memWrite_m = 1'b0; regWrite_m = 1'b0;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_rw", 32'(regWrite_w), 32'd0);
        chk("midrst_err", 32'(mem_err), 32'd0);
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h60, 32'd6, 32'h9876, 32'h0, 0, 32'h0);
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 32'h64, 32'd8, 32'h10C, 32'h0, 1, 32'hA5A5A5A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
